// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// project_types: shared types for the instruction/data memory arbiter.
//   ram_addr_t / ram_data_t : memory bus address and data words
//   chip_status_t           : chip-enable encoding (CHIP_ENABLE / CHIP_DISABLE)
//   arb_state_t             : arbiter FSM states
//   CNT_W                   : width of the access-latency counter (LATENCY 1..4)
// ---------------------------------------------------------------------------
package project_types;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  typedef logic [ADDR_W-1:0] ram_addr_t;
  typedef logic [DATA_W-1:0] ram_data_t;

  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i_membus.sv
// ---------------------------------------------------------------------------
// i_membus: shared single-port memory bus.
//   we    : write enable            ce   : chip enable (chip_status_t)
//   addr  : word address            write: store data
//   read  : read data returned by the memory
// master drives we/ce/addr/write and samples read; slave is the reverse.
// ---------------------------------------------------------------------------
interface i_membus;
  import project_types::*;

  logic         we;
  chip_status_t ce;
  ram_addr_t    addr;
  ram_data_t    write;
  ram_data_t    read;

  modport master (output we, ce, addr, write, input read);
  modport slave  (input we, ce, addr, write, output read);
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter: shares one memory bus between an instruction-fetch port and a
// data load/store port. One access at a time: IDLE -> x_ACC (LATENCY cycles
// with the bus enabled) -> DONE (one-cycle ready pulse) -> IDLE.
//
// Parameters
//   LATENCY : memory read latency in cycles, 1..4
//   D_FIRST : tie winner (1 = data port, 0 = instruction port)
// Ports
//   clk, rst                        : clock, synchronous active-high reset
//   i_req, i_addr -> i_rdata, i_ready : instruction fetch port
//   d_req, d_we, d_addr, d_wdata -> d_rdata, d_ready : data port
//   mem                             : i_membus master
//   stall                           : some request pending and not yet ready
// Build option
//   MEM_ARB_RR_EN : when defined, ties resolve round-robin (the port not
//                   served last wins); D_FIRST then only picks the first
//                   winner after reset.
// ---------------------------------------------------------------------------
module mem_arbiter
  import project_types::*;
#(
  parameter int LATENCY = 1,
  parameter bit D_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_req,
  input  ram_addr_t i_addr,
  output ram_data_t i_rdata,
  output logic      i_ready,
  input  logic      d_req,
  input  logic      d_we,
  input  ram_addr_t d_addr,
  input  ram_data_t d_wdata,
  output ram_data_t d_rdata,
  output logic      d_ready,
  i_membus.master   mem,
  output logic      stall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  arb_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  chip_status_t     ce_q;
  logic             we_q;
  ram_addr_t        addr_q;
  ram_data_t        write_q;
  ram_data_t        i_rdata_q;
  ram_data_t        d_rdata_q;
  logic             i_ready_q;
  logic             d_ready_q;

  logic pick_d_d;  // data port wins when both request
  logic take_d_d;  // data port is granted from IDLE

`ifdef MEM_ARB_RR_EN
  logic last_d_q;  // 1 = data port was served last

  // Seeded so that the first tie after reset goes to D_FIRST.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= ~D_FIRST;
    end else if (state_q == DONE) begin
      last_d_q <= d_ready_q;
    end
  end

  assign pick_d_d = ~last_d_q;
`else
  assign pick_d_d = D_FIRST;
`endif

  assign take_d_d = d_req & (~i_req | pick_d_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ce_q      <= CHIP_DISABLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      write_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            // Requests are latched here; the bus is driven from the latched
            // copy, so a master dropping its request cannot disturb the cycle.
            ce_q  <= CHIP_ENABLE;
            cnt_q <= '0;
            if (take_d_d) begin
              state_q <= D_ACC;
              addr_q  <= d_addr;
              we_q    <= d_we;
              write_q <= d_wdata;
            end else begin
              state_q <= I_ACC;
              addr_q  <= i_addr;
              we_q    <= 1'b0;
              write_q <= '0;
            end
          end
        end
        I_ACC, D_ACC: begin
          if (cnt_q == CNT_LAST) begin
            if (state_q == D_ACC) begin
              if (!we_q) begin
                d_rdata_q <= mem.read;
              end
              d_ready_q <= 1'b1;
            end else begin
              i_rdata_q <= mem.read;
              i_ready_q <= 1'b1;
            end
            ce_q    <= CHIP_DISABLE;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem.ce    = ce_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.write = write_q;

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;

  assign stall = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter: two arbiters (LATENCY 1 and 3), each with a behavioural
// memory that only returns valid read data on the LATENCY-th enabled cycle.
// Expected data comes from a per-DUT word model updated as writes complete.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import project_types::*;

  localparam int NDUT = 2;

  logic      clk = 1'b0;
  logic      rst     [NDUT];
  logic      i_req   [NDUT];
  ram_addr_t i_addr  [NDUT];
  ram_data_t i_rdata [NDUT];
  logic      i_ready [NDUT];
  logic      d_req   [NDUT];
  logic      d_we    [NDUT];
  ram_addr_t d_addr  [NDUT];
  ram_data_t d_wdata [NDUT];
  ram_data_t d_rdata [NDUT];
  logic      d_ready [NDUT];
  logic      stall   [NDUT];
  logic      ce_en   [NDUT];
  logic      m_we    [NDUT];
  ram_addr_t m_addr  [NDUT];
  ram_data_t m_write [NDUT];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  ram_data_t model_mem [NDUT][1024];
  bit        model_set [NDUT][1024];
  ram_data_t exp_i_rdata [NDUT];
  ram_data_t exp_d_rdata [NDUT];
  bit        next_tie_d  [NDUT];  // which port should win the next tie

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic ram_data_t default_word(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  function automatic ram_data_t model_rd(input int k, input ram_addr_t a);
    return model_set[k][a[9:0]] ? model_mem[k][a[9:0]] : default_word(a[9:0]);
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    i_membus bus ();

    mem_arbiter #(.LATENCY(LAT), .D_FIRST(1'b1)) u_dut (
      .clk     (clk),
      .rst     (rst[gi]),
      .i_req   (i_req[gi]),
      .i_addr  (i_addr[gi]),
      .i_rdata (i_rdata[gi]),
      .i_ready (i_ready[gi]),
      .d_req   (d_req[gi]),
      .d_we    (d_we[gi]),
      .d_addr  (d_addr[gi]),
      .d_wdata (d_wdata[gi]),
      .d_rdata (d_rdata[gi]),
      .d_ready (d_ready[gi]),
      .mem     (bus),
      .stall   (stall[gi])
    );

    int        ce_run = 0;
    ram_data_t store  [1024];
    logic      stored [1024] = '{default: 1'b0};

    always @(posedge clk) begin
      if (bus.ce == CHIP_ENABLE) begin
        ce_run <= ce_run + 1;
        if (bus.we) begin
          store[bus.addr[9:0]]  <= bus.write;
          stored[bus.addr[9:0]] <= 1'b1;
        end
      end else begin
        ce_run <= 0;
      end
    end

    // Valid data only on the LAT-th enabled cycle; garbage otherwise.
    assign bus.read = (bus.ce == CHIP_ENABLE && ce_run == LAT - 1)
                    ? (stored[bus.addr[9:0]] ? store[bus.addr[9:0]] : default_word(bus.addr[9:0]))
                    : (32'hBAD0_0000 | 32'(bus.addr[9:0]));

    assign ce_en[gi]   = (bus.ce == CHIP_ENABLE);
    assign m_we[gi]    = bus.we;
    assign m_addr[gi]  = bus.addr;
    assign m_write[gi] = bus.write;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rst_dut(input int k);
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
    rst[k]   = 1'b1;
    @(posedge clk); #1;
    check("rst_ce",      32'(ce_en[k]), 0);
    check("rst_we",      32'(m_we[k]), 0);
    check("rst_addr",    m_addr[k], 0);
    check("rst_write",   m_write[k], 0);
    check("rst_i_rdata", i_rdata[k], 0);
    check("rst_d_rdata", d_rdata[k], 0);
    check("rst_i_ready", 32'(i_ready[k]), 0);
    check("rst_d_ready", 32'(d_ready[k]), 0);
    check("rst_stall",   32'(stall[k]), 0);
    rst[k] = 1'b0;
    exp_i_rdata[k] = '0;
    exp_d_rdata[k] = '0;
    next_tie_d[k]  = 1'b1;
    $display("reset dut%0d", k);
  endtask

  // Single request, nothing competing. Cycles outstanding (request cycle
  // through ready cycle inclusive) must equal LATENCY+2.
  task automatic access(input int k, input bit is_d, input bit we,
                        input ram_addr_t addr, input ram_data_t wdata);
    int        n = 0;
    int        ce_cycles = 0;
    bit        done = 1'b0;
    ram_data_t exp_rd;
    exp_rd = model_rd(k, addr);
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
    end
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ce_en[k]) begin
        ce_cycles++;
        check("bus_we", 32'(m_we[k]), 32'(is_d & we));
        check("bus_addr", m_addr[k], addr);
        if (is_d && we) check("bus_wdata", m_write[k], wdata);
      end else begin
        check("bus_we_idle", 32'(m_we[k]), 0);
      end
      if (is_d ? d_ready[k] : i_ready[k]) done = 1'b1;
      else check("stall_pending", 32'(stall[k]), 1);
    end
    check("ready_seen", 32'(done), 1);
    check("latency", 32'(n + 1), 32'(lat_of(k) + 2));
    check("ce_cycles", 32'(ce_cycles), 32'(lat_of(k)));
    check("other_ready", 32'(is_d ? i_ready[k] : d_ready[k]), 0);
    check("stall_at_ready", 32'(stall[k]), 0);
    if (is_d) begin
      if (we) begin
        model_mem[k][addr[9:0]] = wdata;
        model_set[k][addr[9:0]] = 1'b1;
      end else begin
        exp_d_rdata[k] = exp_rd;
      end
    end else begin
      exp_i_rdata[k] = exp_rd;
    end
    check("i_rdata", i_rdata[k], exp_i_rdata[k]);
    check("d_rdata", d_rdata[k], exp_d_rdata[k]);
`ifdef MEM_ARB_RR_EN
    next_tie_d[k] = ~is_d;
`endif
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
    @(posedge clk); #1;
    check("ready_pulse_end", 32'(i_ready[k] | d_ready[k]), 0);
    check("ce_after_done", 32'(ce_en[k]), 0);
    $display("dut%0d %s %s addr=%0h wdata=%0h cycles=%0d i_rdata=%0h d_rdata=%0h",
             k, is_d ? "D" : "I", (is_d && we) ? "WR" : "RD", addr, wdata, n + 1,
             i_rdata[k], d_rdata[k]);
  endtask

  // Both ports request and hold for 'count' completions.
  task automatic both_held(input int k, input int count, input ram_addr_t ia, input ram_addr_t da);
    int cyc = 0;
    int served = 0;
    bit exp_d;
    i_req[k] = 1'b1; i_addr[k] = ia;
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = da;
    while (served < count && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      check("tie_stall", 32'(stall[k]), 1);
      check("tie_ready_excl", 32'(i_ready[k] & d_ready[k]), 0);
      if (i_ready[k] || d_ready[k]) begin
        exp_d = next_tie_d[k];
`ifdef MEM_ARB_RR_EN
        next_tie_d[k] = ~exp_d;
`endif
        check("tie_winner", 32'(d_ready[k]), 32'(exp_d));
        check("tie_pulse_cycle", 32'(cyc), 32'(lat_of(k) + 1 + served * (lat_of(k) + 2)));
        if (exp_d) exp_d_rdata[k] = model_rd(k, da);
        else       exp_i_rdata[k] = model_rd(k, ia);
        check("tie_i_rdata", i_rdata[k], exp_i_rdata[k]);
        check("tie_d_rdata", d_rdata[k], exp_d_rdata[k]);
        $display("dut%0d tie grant=%s cycle=%0d", k, d_ready[k] ? "D" : "I", cyc);
        served++;
      end
    end
    check("tie_served", 32'(served), 32'(count));
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit        seen;
    ram_data_t exp_v;
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      for (int a = 0; a < 1024; a++) begin
        model_set[k][a] = 1'b0;
        model_mem[k][a] = '0;
      end
    end
    for (int k = 0; k < NDUT; k++) rst_dut(k);

    // Instruction fetch of a word placed at 0x100, fetched after a fresh reset.
    access(0, 1'b1, 1'b1, 32'h100, 32'h2402000A);
    rst_dut(0);
    access(0, 1'b0, 1'b0, 32'h100, '0);
    check("fetch_word", i_rdata[0], 32'h2402000A);

    // Store: bus carries the store, d_rdata keeps its previous value.
    access(0, 1'b1, 1'b0, 32'h010, '0);
    access(0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF);

    // Simultaneous requests held across four completions.
    rst_dut(0);
    both_held(0, 4, 32'h100, 32'h200);

    // LATENCY=3 load.
    access(1, 1'b1, 1'b0, 32'h300, '0);

    // Request dropped mid-access still completes with a ready pulse.
    exp_v = model_rd(1, 32'h040);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h040;
    @(posedge clk); #1;
    check("drop_in_acc", 32'(ce_en[1]), 1);
    d_req[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (d_ready[1]) seen = 1'b1;
    end
    check("drop_ready", 32'(seen), 1);
    exp_d_rdata[1] = exp_v;
    check("drop_rdata", d_rdata[1], exp_v);
`ifdef MEM_ARB_RR_EN
    next_tie_d[1] = 1'b0;
`endif
    $display("dut1 dropped D RD addr=40 ready=%0d d_rdata=%0h", seen, d_rdata[1]);
    @(posedge clk); #1;

    // Reset asserted during an access aborts it without a ready pulse.
    i_req[1] = 1'b1; i_addr[1] = 32'h050;
    @(posedge clk); #1;
    check("abort_in_acc", 32'(ce_en[1]), 1);
    rst_dut(1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (i_ready[1] || d_ready[1]) seen = 1'b1;
    end
    check("abort_no_ready", 32'(seen), 0);
    access(1, 1'b0, 1'b0, 32'h050, '0);
    both_held(1, 4, 32'h060, 32'h300);

    // Randomized single accesses on both latencies.
    for (int k = 0; k < NDUT; k++) begin
      for (int t = 0; t < 25; t++) begin
        bit        rd_d;
        bit        rw;
        ram_addr_t ra;
        rd_d = 1'($urandom_range(0, 1));
        rw   = rd_d & 1'($urandom_range(0, 1));
        ra   = 32'($urandom_range(0, 31));
        access(k, rd_d, rw, ra, 32'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
